// File: rtl/acc_seq_ctrl.sv
// Accumulator sequencer for one FFN systolic-array output column: clear, gate K beats, emit result.
// Optional abort port and behaviour enabled by defining ACC_SEQ_CTRL_ABORT_EN.
module acc_seq_ctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start_i,
  input  logic [CNT_W-1:0]             k_len_i,
  input  logic [CNT_W-1:0]             n_out_i,
  output logic                         busy_o,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic                         acc_en_o,
  output logic                         acc_clr_o,
  input  logic signed [DATA_WIDTH-1:0] acc_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic signed [DATA_WIDTH-1:0] res_data_o,
`ifdef ACC_SEQ_CTRL_ABORT_EN
  input  logic                         abort_i,
`endif
  output logic                         done_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACC    = 3'd2,
    S_SETTLE = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              k_m1_q, n_m1_q, beat_cnt_q, res_cnt_q;
  logic signed [DATA_WIDTH-1:0]  res_data_q;
  logic                          res_valid_q, done_q, abort_clr_q;
  logic                          start_ok, beat, last_beat, last_res, res_hs, abort_hit;

`ifdef ACC_SEQ_CTRL_ABORT_EN
  assign abort_hit = abort_i && (state_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign start_ok  = (state_q == S_IDLE) && start_i;
  assign beat      = (state_q == S_ACC) && in_valid_i;
  assign last_beat = beat && (beat_cnt_q == k_m1_q);
  assign last_res  = (res_cnt_q == n_m1_q);
  assign res_hs    = (state_q == S_OUT) && res_valid_q && res_ready_i && !abort_hit;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort overrides every non-IDLE transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_CLEAR;
      S_CLEAR:  state_d = S_ACC;
      S_ACC:    if (last_beat) state_d = S_SETTLE;
      S_SETTLE: state_d = S_OUT;
      S_OUT:    if (res_hs) state_d = last_res ? S_IDLE : S_CLEAR;
      default:  state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_IDLE;
  end

  // Job latches, counters and result register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_m1_q      <= '0;
      n_m1_q      <= '0;
      beat_cnt_q  <= '0;
      res_cnt_q   <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      abort_clr_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      abort_clr_q <= abort_hit;
      if (start_ok) begin
        // A zero length is treated as one, so the latched terminal count is 0 either way
        k_m1_q    <= (k_len_i == '0) ? '0 : k_len_i - CNT_W'(1);
        n_m1_q    <= (n_out_i == '0) ? '0 : n_out_i - CNT_W'(1);
        res_cnt_q <= '0;
      end
      if (state_q == S_CLEAR) beat_cnt_q <= '0;
      if (beat)               beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      if (state_q == S_SETTLE) begin
        res_data_q  <= acc_i;
        res_valid_q <= 1'b1;
      end
      if (res_hs) begin
        res_valid_q <= 1'b0;
        if (last_res) done_q    <= 1'b1;
        else          res_cnt_q <= res_cnt_q + CNT_W'(1);
      end
      if (abort_hit) res_valid_q <= 1'b0;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign in_ready_o  = (state_q == S_ACC);
  assign acc_en_o    = in_valid_i && in_ready_o;
  assign acc_clr_o   = (state_q == S_CLEAR) || abort_clr_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Scoreboard bench for acc_seq_ctrl: directed jobs drive an external accumulator model,
// expected results are queued and checked by an independent monitor.
module tb_acc_seq_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 start_i = 1'b0;
  logic [CW-1:0]        k_len_i = '0;
  logic [CW-1:0]        n_out_i = '0;
  logic                 busy_o;
  logic                 in_valid_i = 1'b0;
  logic                 in_ready_o;
  logic                 acc_en_o;
  logic                 acc_clr_o;
  logic signed [DW-1:0] acc_q = '0;
  logic                 res_valid_o;
  logic                 res_ready_i = 1'b1;
  logic signed [DW-1:0] res_data_o;
  logic                 done_o;
  logic signed [DW-1:0] beat_data = '0;
`ifdef ACC_SEQ_CTRL_ABORT_EN
  logic                 abort_i = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int clr_cnt  = 0;
  int en_cnt   = 0;
  logic signed [DW-1:0] exp_q[$];
  logic                 stall_prev = 1'b0;
  logic signed [DW-1:0] stall_data = '0;

  always #5 clk = ~clk;

  acc_seq_ctrl #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .k_len_i(k_len_i), .n_out_i(n_out_i),
    .busy_o(busy_o), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .acc_en_o(acc_en_o),
    .acc_clr_o(acc_clr_o), .acc_i(acc_q), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o),
`ifdef ACC_SEQ_CTRL_ABORT_EN
    .abort_i(abort_i),
`endif
    .done_o(done_o)
  );

  // External accumulator: synchronous clear has priority over enable
  always @(posedge clk) begin
    if (acc_clr_o)     acc_q <= '0;
    else if (acc_en_o) acc_q <= acc_q + beat_data;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  // Monitor: result scoreboard, hold stability and handshake invariants
  always @(negedge clk) begin
    if (rstn) begin
      if (done_o)    done_cnt++;
      if (acc_clr_o) clr_cnt++;
      if (acc_en_o)  en_cnt++;
      chk("en_implies_ready", 64'(acc_en_o && !in_ready_o), 64'd0);
      chk("clr_vs_en", 64'(acc_clr_o && acc_en_o), 64'd0);
      if (stall_prev && res_valid_o) chk("data_stable", res_data_o, stall_data);
      if (res_valid_o && res_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_result: got %0d expected none", res_data_o);
        end else begin
          chk("result", res_data_o, exp_q.pop_front());
        end
      end
      stall_prev <= res_valid_o && !res_ready_i;
      stall_data <= res_data_o;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  task automatic do_start(input int k, input int n);
    start_i = 1'b1; k_len_i = CW'(k); n_out_i = CW'(n);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_beat(input logic signed [DW-1:0] d);
    int t = 0;
    in_valid_i = 1'b1; beat_data = d;
    do begin
      @(negedge clk); t++;
    end while (!in_ready_o && t < 50);
    if (!in_ready_o) chk("beat_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    do begin
      @(negedge clk); t++;
    end while (!done_o && t < 100);
    chk({nm, "_done"}, 64'(done_o), 64'd1);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 64'(done_o), 64'd0);
    chk({nm, "_idle"}, 64'(busy_o), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int t = 0;
    do begin
      @(negedge clk); t++;
    end while (!res_valid_o && t < 50);
    chk("valid_timeout", 64'(res_valid_o), 64'd1);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_busy"}, 64'(busy_o), 64'd0);
    chk({nm, "_ready"}, 64'(in_ready_o), 64'd0);
    chk({nm, "_en"}, 64'(acc_en_o), 64'd0);
    chk({nm, "_clr"}, 64'(acc_clr_o), 64'd0);
    chk({nm, "_rvalid"}, 64'(res_valid_o), 64'd0);
    chk({nm, "_done"}, 64'(done_o), 64'd0);
    chk({nm, "_rdata"}, res_data_o, 64'd0);
  endtask

  initial begin
    int c0, e0, d0;
    // 1: reset and idle
    #12 rstn = 1'b1;
    idle(10);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;

    // 2: k=4 n=1 back-to-back, latency T+2
    exp_q.push_back(64'sd10);
    d0 = done_cnt;
    do_start(4, 1);
    send_beat(1); send_beat(2); send_beat(3); send_beat(4);
    @(negedge clk);
    chk("lat_t1", 64'(res_valid_o), 64'd0);
    @(negedge clk);
    chk("lat_t2", 64'(res_valid_o), 64'd1);
    wait_done("t2");
    chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);

    // 3: k=3 n=2 with gaps and a 5-cycle result stall
    exp_q.push_back(64'sd3);
    exp_q.push_back(64'sd6);
    c0 = clr_cnt; e0 = en_cnt;
    res_ready_i = 1'b0;
    do_start(3, 2);
    send_beat(-5); idle(2); send_beat(7); idle(1); send_beat(1);
    wait_valid();
    repeat (5) @(posedge clk);
    #1 res_ready_i = 1'b1;
    send_beat(2); send_beat(2); idle(3); send_beat(2);
    wait_done("t3");
    chk("t3_clr_cnt", 64'(clr_cnt - c0), 64'd2);
    chk("t3_en_cnt", 64'(en_cnt - e0), 64'd6);

    // 4: zero lengths behave as one
    exp_q.push_back(64'sd9);
    do_start(0, 0);
    send_beat(9);
    wait_done("t4");
    chk("t4_queue", 64'(exp_q.size()), 64'd0);

    // 5: start and length changes during a job are ignored
    exp_q.push_back(64'sd3);
    exp_q.push_back(64'sd9);
    do_start(2, 2);
    send_beat(1);
    start_i = 1'b1; k_len_i = CW'(5); n_out_i = CW'(7);
    @(posedge clk); #1 start_i = 1'b0;
    send_beat(2); send_beat(4); send_beat(5);
    wait_done("t5");

    // 6: async reset mid-ACC drops the job
    d0 = done_cnt;
    do_start(4, 1);
    send_beat(1); send_beat(1);
    #2 rstn = 1'b0;
    #1 chk_quiet("midrst");
    @(posedge clk); #1 rstn = 1'b1;
    idle(2);
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
    exp_q.push_back(64'sd2);
    do_start(2, 1);
    send_beat(1); send_beat(1);
    wait_done("t6");

`ifdef ACC_SEQ_CTRL_ABORT_EN
    // Abort while a result is pending
    d0 = done_cnt;
    res_ready_i = 1'b0;
    do_start(1, 1);
    send_beat(7);
    wait_valid();
    @(posedge clk); #1 abort_i = 1'b1;
    @(posedge clk); #1 abort_i = 1'b0;
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_clr", 64'(acc_clr_o), 64'd1);
    chk("abort_rvalid", 64'(res_valid_o), 64'd0);
    res_ready_i = 1'b1;
    idle(3);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
